dmem_responder: RTL and testbench

- Data-memory responder: the far end of the memory-stage control interface (mem_wEn, MemSize, load_extend_sign) produced by the instruction decoder.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs byte/halfword/word access on an internal word array after a configurable wait latency.
- Returns load data extended to 32 bits, plus an error flag, over a valid/ready response handshake.

---
 rtl/dmem_responder_pkg.sv | 34 +++
 rtl/dmem_lane_align.sv | 43 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes (matching the
// instruction decoder's MemSize), FSM state codes and the latched request record.
package dmem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HWORD   = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_INVALID = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wEn;
    logic [1:0]  size;
    logic        sign;
  } memReq_t;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HWORD: bad = offset[0];
      SIZE_WORD:  bad = |offset;
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: merges narrow store data into the
// addressed word and selects/extends the addressed lane for loads.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal  = word_i[{offset_i, 3'b000} +: 8];
    halfVal  = word_i[{offset_i[1], 4'b0000} +: 16];
    merged_o = word_i;
    load_o   = 32'd0;
    case (size_i)
      SIZE_BYTE: begin
        merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {{24{sign_i & byteVal[7]}}, byteVal};
      end
      SIZE_HWORD: begin
        merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        load_o = {{16{sign_i & halfVal[15]}}, halfVal};
      end
      SIZE_WORD: begin
        merged_o = wdata_i;
        load_o   = word_i;
      end
      default: begin
        merged_o = word_i;
        load_o   = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY cycles,
// accesses the word array and returns extended load data plus an error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wEn,
  input  logic [1:0]  MemSize,
  input  logic        load_extend_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int IDXW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  memReq_t     req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rspErr_q, rspErr_d;

  logic            accept;
  logic [IDXW-1:0] wordIdx;
  logic            outOfRange;
  logic            accessErr;
  logic [31:0]     memWord;
  logic [31:0]     mergedWord;
  logic [31:0]     loadVal;
  logic            doStore;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign rsp_err   = rspErr_q;

  // The full word index is range-checked so out-of-range addresses never alias low words.
  assign wordIdx    = req_q.addr[IDXW+1:2];
  assign outOfRange = ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH));
  assign accessErr  = (req_q.size == SIZE_INVALID) || isMisaligned(req_q.size, req_q.addr[1:0])
                      || outOfRange;
  assign memWord    = mem[wordIdx];
  assign doStore    = (state_q == ST_ACCESS) && !req_q.wEn && !accessErr;

  dmem_lane_align u_align (
    .word_i   (memWord),
    .offset_i (req_q.addr[1:0]),
    .size_i   (req_q.size),
    .sign_i   (req_q.sign),
    .wdata_i  (req_q.wdata),
    .merged_o (mergedWord),
    .load_o   (loadVal)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    rspErr_d = rspErr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = '{addr: addr, wdata: wdata, wEn: mem_wEn, size: MemSize, sign: load_extend_sign};
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACCESS: begin
        rdata_d  = (accessErr || !req_q.wEn) ? 32'd0 : loadVal;
        rspErr_d = accessErr;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      req_q    <= '0;
      rdata_q  <= 32'd0;
      rspErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      rdata_q  <= rdata_d;
      rspErr_q <= rspErr_d;
    end
  end

  // Array contents survive reset, so the write port has no reset term.
  always_ff @(posedge clk) begin
    if (doStore) begin
      mem[wordIdx] <= mergedWord;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven load/store vectors checked
// through a response scoreboard, plus backpressure and mid-operation reset sequences.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  typedef struct {
    string       name;
    logic        wEn;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          acceptCycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_wEn = 1'b1;
  logic [1:0]  MemSize = SIZE_WORD;
  logic        load_extend_sign = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rdata;
  logic        rsp_err;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycle = 0;
  exp_t sbQ[$];
  vec_t vecs[$];
  logic prevValid = 1'b0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .addr             (addr),
    .wdata            (wdata),
    .mem_wEn          (mem_wEn),
    .MemSize          (MemSize),
    .load_extend_sign (load_extend_sign),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rdata            (rdata),
    .rsp_err          (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic vec_t mk(input string name, input logic wEn, input logic [1:0] size,
                              input logic sign, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] expData, input logic expErr);
    vec_t v;
    v.name = name; v.wEn = wEn; v.size = size; v.sign = sign;
    v.addr = a; v.wdata = wd; v.expData = expData; v.expErr = expErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit expectRsp, output int acceptCycle);
    exp_t e;
    bit   done;
    done = 1'b0;
    acceptCycle = -1;
    req_valid        = 1'b1;
    addr             = v.addr;
    wdata            = v.wdata;
    mem_wEn          = v.wEn;
    MemSize          = v.size;
    load_extend_sign = v.sign;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acceptCycle = cycle + 1;
        if (expectRsp) begin
          e.name = v.name; e.data = v.expData; e.err = v.expErr; e.acceptCycle = acceptCycle;
          sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s accept: got no accept, expected accept within 40 cycles", v.name);
    end
    req_valid        = 1'b0;
    addr             = $urandom;
    wdata            = $urandom;
    mem_wEn          = 1'($urandom_range(0, 1));
    MemSize          = 2'($urandom_range(0, 3));
    load_extend_sign = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s drain: got %0d outstanding responses, expected 0", name, sbQ.size());
      sbQ.delete();
    end
  endtask

  // Scoreboard side: latency on the rising edge of rsp_valid, data/err on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_valid && !prevValid && sbQ.size() != 0) begin
        checkOutput({sbQ[0].name, " latency"}, 32'(cycle - sbQ[0].acceptCycle), 32'(LATENCY + 1));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected response: got rdata 0x%08h err %0b, expected none", rdata, rsp_err);
        end else begin
          e = sbQ.pop_front();
          checkOutput({e.name, " rdata"}, rdata, e.data);
          checkOutput({e.name, " rsp_err"}, 32'(rsp_err), 32'(e.err));
        end
      end
    end
    prevValid = rsp_valid;
  end

  initial begin
    int acc;
    int acc2;
    int releaseCycle;
    bit seen;

    vecs.push_back(mk("sw 0x10",      1'b0, SIZE_WORD,    1'b0, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0));
    vecs.push_back(mk("lw 0x10",      1'b1, SIZE_WORD,    1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("lw sign 0x10", 1'b1, SIZE_WORD,    1'b1, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("sw 0x20",      1'b0, SIZE_WORD,    1'b0, 32'h20,  32'h11223344, 32'h0, 1'b0));
    vecs.push_back(mk("sb 0x22",      1'b0, SIZE_BYTE,    1'b0, 32'h22,  32'hFFFFFFAA, 32'h0, 1'b0));
    vecs.push_back(mk("lw 0x20 a",    1'b1, SIZE_WORD,    1'b0, 32'h20,  32'h0, 32'h11AA3344, 1'b0));
    vecs.push_back(mk("sh 0x20",      1'b0, SIZE_HWORD,   1'b0, 32'h20,  32'h1234BEEF, 32'h0, 1'b0));
    vecs.push_back(mk("lw 0x20 b",    1'b1, SIZE_WORD,    1'b0, 32'h20,  32'h0, 32'h11AABEEF, 1'b0));
    vecs.push_back(mk("sw 0x30",      1'b0, SIZE_WORD,    1'b0, 32'h30,  32'h0080FF7F, 32'h0, 1'b0));
    vecs.push_back(mk("lb 0x31",      1'b1, SIZE_BYTE,    1'b1, 32'h31,  32'h0, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("lbu 0x31",     1'b1, SIZE_BYTE,    1'b0, 32'h31,  32'h0, 32'h000000FF, 1'b0));
    vecs.push_back(mk("lh 0x32",      1'b1, SIZE_HWORD,   1'b1, 32'h32,  32'h0, 32'h00000080, 1'b0));
    vecs.push_back(mk("lhu 0x30",     1'b1, SIZE_HWORD,   1'b0, 32'h30,  32'h0, 32'h0000FF7F, 1'b0));
    vecs.push_back(mk("lh 0x30",      1'b1, SIZE_HWORD,   1'b1, 32'h30,  32'h0, 32'hFFFFFF7F, 1'b0));
    vecs.push_back(mk("lb 0x32",      1'b1, SIZE_BYTE,    1'b1, 32'h32,  32'h0, 32'hFFFFFF80, 1'b0));
    vecs.push_back(mk("lbu 0x33",     1'b1, SIZE_BYTE,    1'b0, 32'h33,  32'h0, 32'h00000000, 1'b0));
    vecs.push_back(mk("lb 0x30",      1'b1, SIZE_BYTE,    1'b1, 32'h30,  32'h0, 32'h0000007F, 1'b0));
    vecs.push_back(mk("lw 0x22 mis",  1'b1, SIZE_WORD,    1'b0, 32'h22,  32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sh 0x33 mis",  1'b0, SIZE_HWORD,   1'b0, 32'h33,  32'h0000FFFF, 32'h0, 1'b1));
    vecs.push_back(mk("ld size11",    1'b1, SIZE_INVALID, 1'b0, 32'h30,  32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("st size11",    1'b0, SIZE_INVALID, 1'b0, 32'h30,  32'hFFFFFFFF, 32'h0, 1'b1));
    vecs.push_back(mk("lw 0x30 kept", 1'b1, SIZE_WORD,    1'b0, 32'h30,  32'h0, 32'h0080FF7F, 1'b0));
    vecs.push_back(mk("lh 0x21 mis",  1'b1, SIZE_HWORD,   1'b1, 32'h21,  32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sw 0x0",       1'b0, SIZE_WORD,    1'b0, 32'h0,   32'hCAFEF00D, 32'h0, 1'b0));
    vecs.push_back(mk("sw DEPTH*4",   1'b0, SIZE_WORD,    1'b0, 32'(DEPTH * 4), 32'h55555555, 32'h0, 1'b1));
    vecs.push_back(mk("lw DEPTH*4",   1'b1, SIZE_WORD,    1'b0, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk("sw 0x8000_0000", 1'b0, SIZE_WORD,  1'b0, 32'h80000000, 32'h12121212, 32'h0, 1'b1));
    vecs.push_back(mk("lw 0x0 kept",  1'b1, SIZE_WORD,    1'b0, 32'h0,   32'h0, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk("sb 0x13",      1'b0, SIZE_BYTE,    1'b0, 32'h13,  32'h00000077, 32'h0, 1'b0));
    vecs.push_back(mk("sh 0x12",      1'b0, SIZE_HWORD,   1'b0, 32'h12,  32'hABCD9999, 32'h0, 1'b0));
    vecs.push_back(mk("lw 0x10 c",    1'b1, SIZE_WORD,    1'b0, 32'h10,  32'h0, 32'h9999BEEF, 1'b0));
    vecs.push_back(mk("lhu 0x12",     1'b1, SIZE_HWORD,   1'b0, 32'h12,  32'h0, 32'h00009999, 1'b0));
    vecs.push_back(mk("lh 0x12",      1'b1, SIZE_HWORD,   1'b1, 32'h12,  32'h0, 32'hFFFF9999, 1'b0));

    #1 rst = 1'b1;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1, acc);
    end
    waitDrain("table");

    // Backpressure: hold the response while a new request waits.
    $display("[TB] backpressure sequence");
    rsp_ready = 1'b0;
    applyStimulus(mk("bp lw 0x20", 1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0, 32'h11AABEEF, 1'b0), 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    checkOutput("bp rsp_valid seen", 32'(seen), 32'd1);
    releaseCycle = 0;
    fork
      applyStimulus(mk("bp lw 0x10", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h9999BEEF, 1'b0), 1'b1, acc2);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
          checkOutput("bp hold rdata", rdata, 32'h11AABEEF);
          checkOutput("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        releaseCycle = cycle;
        rsp_ready = 1'b1;
      end
    join
    checkOutput("bp accept cycle", 32'(acc2), 32'(releaseCycle + 2));
    waitDrain("backpressure");

    // Reset during WAIT must drop the store and clear the outputs at once.
    $display("[TB] reset mid-operation sequence");
    applyStimulus(mk("sw 0x40 zero", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0), 1'b1, acc);
    applyStimulus(mk("lw 0x10 pre", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h9999BEEF, 1'b0), 1'b1, acc);
    waitDrain("pre reset");
    applyStimulus(mk("sw 0x40 drop", 1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h12345678, 32'h0, 1'b0), 1'b0, acc);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst req_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst rdata", rdata, 32'd0);
    checkOutput("midrst rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(mk("lw 0x40 post", 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h00000000, 1'b0), 1'b1, acc);
    waitDrain("post reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
